// File: rtl/interlaken_seq_pkg.sv
// Shared definitions for the Interlaken latency-test sequencers.
// The driver side and the repeater side both use the state encodings and
// handshake codes below, so the two ends of the link agree on them.
package interlaken_seq_pkg;

    localparam int STATE_W = 4;
    typedef logic [STATE_W-1:0] seq_state_t;

    localparam seq_state_t ST_GT_LOCK_WAIT  = 4'd0;
    localparam seq_state_t ST_RX_ALIGN_WAIT = 4'd1;
    localparam seq_state_t ST_HS_WAIT       = 4'd2;
    localparam seq_state_t ST_HS_ACK        = 4'd3;
    localparam seq_state_t ST_RESTART_PULSE = 4'd4;
    localparam seq_state_t ST_BUSY_WAIT     = 4'd5;
    localparam seq_state_t ST_SESSION_RUN   = 4'd6;
    localparam seq_state_t ST_SESSION_DRAIN = 4'd7;
    localparam seq_state_t ST_DONE          = 4'd8;
    localparam seq_state_t ST_FAIL          = 4'd9;

    localparam logic [7:0] HS_REQ_START   = 8'hA5;
    localparam logic [7:0] HS_REQ_RESTART = 8'hC3;
    localparam logic [7:0] HS_ACK_START   = 8'h5A;
    localparam logic [7:0] HS_ACK_RESTART = 8'h3C;

    // States in which the sequencer is waiting on an external event and
    // must give up after the timeout window.
    function automatic logic is_timed_state(seq_state_t s);
        return (s == ST_RX_ALIGN_WAIT) || (s == ST_HS_WAIT) ||
               (s == ST_BUSY_WAIT) || (s == ST_SESSION_RUN) ||
               (s == ST_SESSION_DRAIN);
    endfunction

    // States that require the RX lanes to stay aligned.
    function automatic logic needs_align(seq_state_t s);
        return (s >= ST_HS_WAIT) && (s <= ST_SESSION_DRAIN);
    endfunction

endpackage

// File: rtl/interlaken_seq_timeout_cntr.sv
// Loadable, clearable up-counter with an expiry strobe.
// 'expired' is a pure decode of the current count so a caller can fold it
// into next-state logic and clear the counter in the same cycle.
module interlaken_seq_timeout_cntr #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] count;

    // Clear wins over load, load wins over count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en)
            count <= count + 1'b1;
    end

    assign expired = en && (count == limit);

endmodule

// File: rtl/interlaken_rpt_seq_responder.sv
// Repeater-side test sequencer: answers the driver's START/RESTART
// handshake, restarts the local LBUS exdes, and tracks each packet session
// through to completion, reporting timeouts and RX failures.
module interlaken_rpt_seq_responder
    import interlaken_seq_pkg::*;
#(
    parameter logic [19:0] TIMEOUT_CYCLES = 20'hF_FFFF,
    parameter int          NUM_SESSIONS   = 2,
    parameter logic [7:0]  REQ_START      = HS_REQ_START,
    parameter logic [7:0]  REQ_RESTART    = HS_REQ_RESTART,
    parameter logic [7:0]  ACK_START      = HS_ACK_START,
    parameter logic [7:0]  ACK_RESTART    = HS_ACK_RESTART
) (
    input  logic         init_clk,
    input  logic         sys_reset_n,
    input  logic         rx_gt_locked,
    input  logic         rx_aligned,
    input  logic         hs_req_valid,
    input  logic [7:0]   hs_req_code,
    input  logic         hs_ack_ready,
    output logic         hs_ack_valid,
    output logic [7:0]   hs_ack_code,
    input  logic         tx_busy,
    input  logic         tx_done,
    input  logic         rx_busy,
    input  logic         rx_done,
    input  logic         rx_failed,
    output logic         lbus_tx_rx_restart,
    output logic [3:0]   state,
    output logic [3:0]   sessions_done,
    output logic [7:0]   bad_req_cnt,
    output logic         timed_out,
    output logic         rx_failed_flag,
    output logic         test_done
);

    localparam logic [19:0] TMO_LIMIT = TIMEOUT_CYCLES - 20'd1;
    localparam logic [3:0]  SESS_LAST = NUM_SESSIONS[3:0];

    seq_state_t state_q, state_nxt;
    logic [3:0] sess_q;
    logic [7:0] bad_q;
    logic [7:0] ack_code_q;
    logic       tx_done_lat, rx_done_lat;
    logic       timed_out_q, rx_failed_q;

    logic       tmo_exp, tmo_clr, tmo_en;
    logic       align_lost;
    logic       ack_load, bad_inc, sess_inc;
    logic [7:0] exp_req, exp_ack;
    logic [3:0] sess_next;

    assign align_lost = !rx_aligned && needs_align(state_q);
    assign exp_req    = (sess_q == 4'd0) ? REQ_START : REQ_RESTART;
    assign exp_ack    = (sess_q == 4'd0) ? ACK_START : ACK_RESTART;
    assign sess_next  = sess_q + 4'd1;
    assign tmo_en     = is_timed_state(state_q);
    assign tmo_clr    = (state_nxt != state_q) || !tmo_en;

    interlaken_seq_timeout_cntr #(.W(20)) u_tmo (
        .clk      (init_clk),
        .rst_n    (sys_reset_n),
        .clr      (tmo_clr),
        .load     (1'b0),
        .load_val (20'd0),
        .en       (tmo_en),
        .limit    (TMO_LIMIT),
        .expired  (tmo_exp)
    );

    // Next-state decode; alignment loss overrides timeout, which overrides
    // the normal transition. Side effects only fire on the normal path.
    always_comb begin
        state_nxt = state_q;
        ack_load  = 1'b0;
        bad_inc   = 1'b0;
        sess_inc  = 1'b0;
        case (state_q)
            ST_GT_LOCK_WAIT:  if (rx_gt_locked) state_nxt = ST_RX_ALIGN_WAIT;
            ST_RX_ALIGN_WAIT: if (rx_aligned) state_nxt = ST_HS_WAIT;
            ST_HS_WAIT: begin
                if (hs_req_valid) begin
                    if (hs_req_code == exp_req) begin
                        state_nxt = ST_HS_ACK;
                        ack_load  = 1'b1;
                    end else begin
                        bad_inc = 1'b1;
                    end
                end
            end
            ST_HS_ACK:        if (hs_ack_ready) state_nxt = ST_RESTART_PULSE;
            // Session 1 needs no restart: the exdes starts on alignment.
            ST_RESTART_PULSE: state_nxt = (sess_q == 4'd0) ? ST_SESSION_RUN : ST_BUSY_WAIT;
            ST_BUSY_WAIT:     if (tx_busy && rx_busy) state_nxt = ST_SESSION_RUN;
            ST_SESSION_RUN: begin
                if ((tx_done || tx_done_lat) && (rx_done || rx_done_lat))
                    state_nxt = ST_SESSION_DRAIN;
            end
            ST_SESSION_DRAIN: begin
                if (!tx_busy && !rx_busy) begin
                    sess_inc  = 1'b1;
                    state_nxt = (sess_next == SESS_LAST) ? ST_DONE : ST_HS_WAIT;
                end
            end
            default: state_nxt = state_q;
        endcase
        if (tmo_exp || align_lost) begin
            ack_load = 1'b0;
            bad_inc  = 1'b0;
            sess_inc = 1'b0;
        end
        if (tmo_exp)    state_nxt = ST_FAIL;
        if (align_lost) state_nxt = ST_RX_ALIGN_WAIT;
    end

    // State, counters and handshake code.
    always_ff @(posedge init_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state_q    <= ST_GT_LOCK_WAIT;
            sess_q     <= 4'd0;
            bad_q      <= 8'd0;
            ack_code_q <= 8'd0;
        end else begin
            state_q <= state_nxt;
            if (sess_inc) sess_q <= sess_next;
            if (bad_inc && bad_q != 8'hFF) bad_q <= bad_q + 8'd1;
            if (ack_load) ack_code_q <= exp_ack;
        end
    end

    // Done latches live only while the session stays in SESSION_RUN.
    always_ff @(posedge init_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            tx_done_lat <= 1'b0;
            rx_done_lat <= 1'b0;
        end else if (state_q == ST_SESSION_RUN && state_nxt == ST_SESSION_RUN) begin
            tx_done_lat <= tx_done_lat | tx_done;
            rx_done_lat <= rx_done_lat | rx_done;
        end else begin
            tx_done_lat <= 1'b0;
            rx_done_lat <= 1'b0;
        end
    end

    // Sticky status flags.
    always_ff @(posedge init_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            timed_out_q <= 1'b0;
            rx_failed_q <= 1'b0;
        end else begin
            if (tmo_exp && !align_lost) timed_out_q <= 1'b1;
            if (rx_failed)              rx_failed_q <= 1'b1;
        end
    end

    assign hs_ack_valid       = (state_q == ST_HS_ACK);
    assign hs_ack_code        = ack_code_q;
    assign lbus_tx_rx_restart = (state_q == ST_RESTART_PULSE) && (sess_q != 4'd0);
    assign state              = state_q;
    assign sessions_done      = sess_q;
    assign bad_req_cnt        = bad_q;
    assign timed_out          = timed_out_q;
    assign rx_failed_flag     = rx_failed_q;
    assign test_done          = (state_q == ST_DONE);

endmodule
